tlb_maint_engine: RTL and testbench



---
 rtl/tlb_pkg.sv | 53 +++++
 rtl/tlb_maint_engine_if.sv | 41 ++++
 rtl/tlb_ent_match.sv | 29 ++
 rtl/tlb_maint_engine.sv | 182 ++++++++++++++++++
 tb/tb_tlb_maint_engine.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// ============================================================================
// Module : tlb_pkg
// Brief  : Shared encodings for the TLB maintenance engine: command ops,
//          INVTLB op codes, FSM states and page-size constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tlb_pkg;

    localparam logic [1:0] OP_SRCH = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_INV  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    localparam logic [2:0] INV_ALL0         = 3'd0;
    localparam logic [2:0] INV_ALL1         = 3'd1;
    localparam logic [2:0] INV_GLB          = 3'd2;
    localparam logic [2:0] INV_NGLB         = 3'd3;
    localparam logic [2:0] INV_NGLB_ASID    = 3'd4;
    localparam logic [2:0] INV_NGLB_ASID_VA = 3'd5;
    localparam logic [2:0] INV_GLB_ASID_VA  = 3'd6;
    localparam logic [2:0] INV_NOP          = 3'd7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SCAN = 3'd1;
    localparam logic [2:0] ST_READ = 3'd2;
    localparam logic [2:0] ST_INV  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    // Operands captured at command acceptance.
    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  inv_op;
        logic [9:0]  asid;
        logic [18:0] vppn;
    } tlb_cmd_t;

    // A 2M page ignores the low 9 VPPN bits; everything else compares fully.
    function automatic logic tlb_vppn_eq(input logic [5:0]  ps,
                                         input logic [18:0] ent_vppn,
                                         input logic [18:0] key_vppn);
        if (ps == PS_2M)
            return ent_vppn[18:9] == key_vppn[18:9];
        return ent_vppn == key_vppn;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlb_maint_engine_if.sv
// ============================================================================
// Module : tlb_maint_engine_if
// Brief  : Command handshake and TLBIDX result bundle between the issue stage
//          (master) and the maintenance engine (slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tlb_maint_engine_if #(
    parameter int IDX_W = 6
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [2:0]       cmd_inv_op;
    logic [9:0]       csr_asid;
    logic [18:0]      csr_vppn;
    logic [IDX_W-1:0] csr_idx;

    logic             TLBSRCH;
    logic             TLBSRCH_hit;
    logic [IDX_W-1:0] TLBSRCH_hit_idx;
    logic             TLBRD_en;
    logic [5:0]       TLB_PS;
    logic             TLB_E;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_inv_op, csr_asid, csr_vppn, csr_idx,
        input  cmd_ready, TLBSRCH, TLBSRCH_hit, TLBSRCH_hit_idx,
               TLBRD_en, TLB_PS, TLB_E, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_inv_op, csr_asid, csr_vppn, csr_idx,
        output cmd_ready, TLBSRCH, TLBSRCH_hit, TLBSRCH_hit_idx,
               TLBRD_en, TLB_PS, TLB_E, done
    );
endinterface

`default_nettype wire

// File: rtl/tlb_ent_match.sv
// ============================================================================
// Module : tlb_ent_match
// Brief  : Combinational compare of one TLB entry against an ASID/VPPN key.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlb_ent_match
    import tlb_pkg::*;
(
    input  wire logic        ent_e,
    input  wire logic        ent_g,
    input  wire logic [9:0]  ent_asid,
    input  wire logic [18:0] ent_vppn,
    input  wire logic [5:0]  ent_ps,
    input  wire logic [9:0]  key_asid,
    input  wire logic [18:0] key_vppn,
    output logic             asid_eq,
    output logic             vppn_eq,
    output logic             hit
);

    assign asid_eq = (ent_asid == key_asid);
    assign vppn_eq = tlb_vppn_eq(ent_ps, ent_vppn, key_vppn);
    assign hit     = ent_e & (ent_g | asid_eq) & vppn_eq;

endmodule

`default_nettype wire

// File: rtl/tlb_maint_engine.sv
// ============================================================================
// Module : tlb_maint_engine
// Brief  : Multi-cycle TLBSRCH / TLBRD / INVTLB engine driving the TLB array's
//          asynchronous read port. INVTLB is built only with TLB_INVTLB_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tlb_maint_engine
    import tlb_pkg::*;
#(
    parameter int TLB_NUM = 64,
    parameter int IDX_W   = 6
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    tlb_maint_engine_if.slave     cmd_if,
    output logic [IDX_W-1:0]      ent_idx,
    input  wire logic             ent_e,
    input  wire logic             ent_g,
    input  wire logic [9:0]       ent_asid,
    input  wire logic [18:0]      ent_vppn,
    input  wire logic [5:0]       ent_ps,
    output logic                  ent_clr
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(TLB_NUM - 1);

    logic [2:0]       r_state;
    tlb_cmd_t         r_cmd;
    logic [IDX_W-1:0] r_idx;
    logic             r_srch_pulse;
    logic             r_rd_pulse;
    logic             r_done_pulse;
    logic             r_hit;
    logic [IDX_W-1:0] r_hit_idx;
    logic [5:0]       r_ps;
    logic             r_e;

    logic             w_asid_eq;
    logic             w_vppn_eq;
    logic             w_hit;
    logic             w_last;
    logic             w_inv_en;

    tlb_ent_match u_match (
        .ent_e    (ent_e),
        .ent_g    (ent_g),
        .ent_asid (ent_asid),
        .ent_vppn (ent_vppn),
        .ent_ps   (ent_ps),
        .key_asid (r_cmd.asid),
        .key_vppn (r_cmd.vppn),
        .asid_eq  (w_asid_eq),
        .vppn_eq  (w_vppn_eq),
        .hit      (w_hit)
    );

    assign w_last = (r_idx == c_last_idx);

`ifdef TLB_INVTLB_EN
    logic w_inv_sel;

    assign w_inv_en = 1'b1;

    // INVTLB selection ignores E: clearing an already-invalid entry is harmless.
    always_comb begin
        w_inv_sel = 1'b0;
        case (r_cmd.inv_op)
            INV_ALL0, INV_ALL1: w_inv_sel = 1'b1;
            INV_GLB:            w_inv_sel = ent_g;
            INV_NGLB:           w_inv_sel = ~ent_g;
            INV_NGLB_ASID:      w_inv_sel = ~ent_g & w_asid_eq;
            INV_NGLB_ASID_VA:   w_inv_sel = ~ent_g & w_asid_eq & w_vppn_eq;
            INV_GLB_ASID_VA:    w_inv_sel = (ent_g | w_asid_eq) & w_vppn_eq;
            default:            w_inv_sel = 1'b0;
        endcase
    end

    assign ent_clr = (r_state == ST_INV) & w_inv_sel;
`else
    logic w_unused_inv;

    assign w_inv_en     = 1'b0;
    assign ent_clr      = 1'b0;
    assign w_unused_inv = ^{r_cmd.inv_op, w_asid_eq, w_vppn_eq};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_idx        <= '0;
            r_srch_pulse <= 1'b0;
            r_rd_pulse   <= 1'b0;
            r_done_pulse <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_idx    <= '0;
            r_ps         <= '0;
            r_e          <= 1'b0;
        end else begin
            r_srch_pulse <= 1'b0;
            r_rd_pulse   <= 1'b0;
            r_done_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_if.cmd_valid) begin
                        r_cmd.op     <= cmd_if.cmd_op;
                        r_cmd.inv_op <= cmd_if.cmd_inv_op;
                        r_cmd.asid   <= cmd_if.csr_asid;
                        r_cmd.vppn   <= cmd_if.csr_vppn;
                        case (cmd_if.cmd_op)
                            OP_SRCH: begin
                                r_state <= ST_SCAN;
                                r_idx   <= '0;
                            end
                            OP_RD: begin
                                r_state <= ST_READ;
                                r_idx   <= cmd_if.csr_idx;
                            end
                            OP_INV: begin
                                if (w_inv_en) begin
                                    r_state <= ST_INV;
                                    r_idx   <= '0;
                                end else begin
                                    r_state      <= ST_DONE;
                                    r_done_pulse <= 1'b1;
                                end
                            end
                            default: begin
                                r_state      <= ST_DONE;
                                r_done_pulse <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_SCAN: begin
                    if (w_hit || w_last) begin
                        r_state      <= ST_DONE;
                        r_srch_pulse <= 1'b1;
                        r_done_pulse <= 1'b1;
                        r_hit        <= w_hit;
                        if (w_hit)
                            r_hit_idx <= r_idx;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_READ: begin
                    r_state      <= ST_DONE;
                    r_rd_pulse   <= 1'b1;
                    r_done_pulse <= 1'b1;
                    r_ps         <= ent_ps;
                    r_e          <= ent_e;
                end
                ST_INV: begin
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_done_pulse <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ent_idx                = r_idx;
    assign cmd_if.cmd_ready       = (r_state == ST_IDLE);
    assign cmd_if.TLBSRCH         = r_srch_pulse;
    assign cmd_if.TLBSRCH_hit     = r_hit;
    assign cmd_if.TLBSRCH_hit_idx = r_hit_idx;
    assign cmd_if.TLBRD_en        = r_rd_pulse;
    assign cmd_if.TLB_PS          = r_ps;
    assign cmd_if.TLB_E           = r_e;
    assign cmd_if.done            = r_done_pulse;

endmodule

`default_nettype wire

// File: tb/tb_tlb_maint_engine.sv
// ============================================================================
// Module : tb_tlb_maint_engine
// Brief  : Directed plus random commands against a behavioural TLB model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tlb_maint_engine;

    localparam int TLB_NUM = 64;
    localparam int IDX_W   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlb_maint_engine_if #(.IDX_W(IDX_W)) bus ();

    logic [IDX_W-1:0] ent_idx;
    logic             ent_e, ent_g, ent_clr;
    logic [9:0]       ent_asid;
    logic [18:0]      ent_vppn;
    logic [5:0]       ent_ps;

    bit          m_e    [TLB_NUM];
    bit          m_g    [TLB_NUM];
    logic [9:0]  m_asid [TLB_NUM];
    logic [18:0] m_vppn [TLB_NUM];
    logic [5:0]  m_ps   [TLB_NUM];

    assign ent_e    = m_e[ent_idx];
    assign ent_g    = m_g[ent_idx];
    assign ent_asid = m_asid[ent_idx];
    assign ent_vppn = m_vppn[ent_idx];
    assign ent_ps   = m_ps[ent_idx];

    tlb_maint_engine #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_if   (bus),
        .ent_idx  (ent_idx),
        .ent_e    (ent_e),
        .ent_g    (ent_g),
        .ent_asid (ent_asid),
        .ent_vppn (ent_vppn),
        .ent_ps   (ent_ps),
        .ent_clr  (ent_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected TLBIDX result fields, held between results of the same type.
    bit         x_hit     = 0;
    int         x_hit_idx = 0;
    int         x_ps      = 0;
    bit         x_e       = 0;

`ifdef TLB_INVTLB_EN
    localparam bit INV_BUILT = 1'b1;
`else
    localparam bit INV_BUILT = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit m_match(int i, logic [9:0] a, logic [18:0] v);
        bit vp;
        vp = (m_ps[i] == 21) ? ((m_vppn[i] >> 9) == (v >> 9)) : (m_vppn[i] == v);
        return m_e[i] && (m_g[i] || m_asid[i] == a) && vp;
    endfunction

    function automatic bit m_inv_sel(int i, int op, logic [9:0] a, logic [18:0] v);
        bit vp, am;
        vp = (m_ps[i] == 21) ? ((m_vppn[i] >> 9) == (v >> 9)) : (m_vppn[i] == v);
        am = (m_asid[i] == a);
        case (op)
            0, 1:    return 1;
            2:       return m_g[i];
            3:       return !m_g[i];
            4:       return !m_g[i] && am;
            5:       return !m_g[i] && am && vp;
            6:       return (m_g[i] || am) && vp;
            default: return 0;
        endcase
    endfunction

    task automatic clear_entries();
        for (int i = 0; i < TLB_NUM; i++) begin
            m_e[i] = 0; m_g[i] = 0; m_asid[i] = '0; m_vppn[i] = '0; m_ps[i] = 6'd12;
        end
    endtask

    task automatic rand_entries();
        for (int i = 0; i < TLB_NUM; i++) begin
            m_e[i]    = ($urandom_range(0, 3) == 0);
            m_g[i]    = ($urandom_range(0, 4) == 0);
            m_asid[i] = 10'($urandom_range(0, 3));
            m_vppn[i] = 19'h12000 | 19'($urandom_range(0, 3) << 9) | 19'($urandom_range(0, 1));
            m_ps[i]   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
        end
    endtask

    task automatic run_cmd(input string tag, input int op, input int inv,
                           input logic [9:0] asid, input logic [18:0] vppn, input int idx);
        int           exp_lat, lat, n;
        bit           exp_srch, exp_rd, got, ready_ok;
        logic [63:0]  exp_clr, got_clr;
        exp_srch = 0; exp_rd = 0; exp_clr = '0; got_clr = '0;
        if (op == 0) begin
            exp_srch = 1;
            exp_lat  = 1 + TLB_NUM;
            x_hit    = 0;
            for (int i = TLB_NUM - 1; i >= 0; i--)
                if (m_match(i, asid, vppn)) begin
                    exp_lat = 2 + i; x_hit = 1; x_hit_idx = i;
                end
        end else if (op == 1) begin
            exp_rd  = 1; exp_lat = 2;
            x_ps    = m_ps[idx]; x_e = m_e[idx];
        end else if (op == 2 && INV_BUILT) begin
            exp_lat = 1 + TLB_NUM;
            for (int i = 0; i < TLB_NUM; i++)
                exp_clr[i] = m_inv_sel(i, inv, asid, vppn);
        end else begin
            exp_lat = 1;
        end

        @(negedge clk);
        check({tag, "_ready_idle"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'(op); bus.cmd_inv_op = 3'(inv);
        bus.csr_asid = asid; bus.csr_vppn = vppn; bus.csr_idx = IDX_W'(idx);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.csr_asid = 10'($urandom); bus.csr_vppn = 19'($urandom); bus.csr_idx = IDX_W'($urandom);

        n = 1; got = 0; lat = 0; ready_ok = 1;
        while (!got && n <= TLB_NUM + 8) begin
            if (ent_clr) got_clr[ent_idx] = 1'b1;
            if (bus.done) begin
                got = 1; lat = n;
            end else begin
                if (bus.cmd_ready || bus.TLBSRCH || bus.TLBRD_en) ready_ok = 0;
                @(posedge clk); #1;
                n++;
            end
        end

        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(ready_ok), 64'd1);
        check({tag, "_srch_pulse"}, 64'(bus.TLBSRCH), 64'(exp_srch));
        check({tag, "_rd_pulse"}, 64'(bus.TLBRD_en), 64'(exp_rd));
        check({tag, "_hit"}, 64'(bus.TLBSRCH_hit), 64'(x_hit));
        check({tag, "_hit_idx"}, 64'(bus.TLBSRCH_hit_idx), 64'(x_hit_idx));
        check({tag, "_ps"}, 64'(bus.TLB_PS), 64'(x_ps));
        check({tag, "_e"}, 64'(bus.TLB_E), 64'(x_e));
        check({tag, "_clr_mask"}, got_clr, exp_clr);

        @(posedge clk); #1;
        check({tag, "_pulse_end"}, 64'({bus.done, bus.TLBSRCH, bus.TLBRD_en}), 64'd0);
        check({tag, "_ready_back"}, 64'(bus.cmd_ready), 64'd1);

        for (int i = 0; i < TLB_NUM; i++)
            if (exp_clr[i]) m_e[i] = 0;
    endtask

    initial begin
        int pulses;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_inv_op = '0;
        bus.csr_asid = '0; bus.csr_vppn = '0; bus.csr_idx = '0;
        clear_entries();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_fields", 64'({bus.TLBSRCH, bus.TLBRD_en, bus.done, bus.TLBSRCH_hit,
                                bus.TLBSRCH_hit_idx, bus.TLB_PS, bus.TLB_E, ent_clr, ent_idx}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single non-global entry: hit at index 5, then ASID mismatch misses.
        m_e[5] = 1; m_g[5] = 0; m_asid[5] = 10'd3; m_vppn[5] = 19'h12345; m_ps[5] = 6'd12;
        run_cmd("srch_hit5", 0, 0, 10'd3, 19'h12345, 0);
        run_cmd("srch_miss", 0, 0, 10'd4, 19'h12345, 0);

        // Lowest index wins even when a higher one matches through G.
        clear_entries();
        m_e[9] = 1;  m_asid[9] = 10'd7;  m_vppn[9] = 19'h0abcd;
        m_e[40] = 1; m_g[40] = 1; m_asid[40] = 10'd1; m_vppn[40] = 19'h0abcd;
        run_cmd("srch_first", 0, 0, 10'd7, 19'h0abcd, 0);

        // 2M page ignores the low VPPN bits; a 4K page does not.
        clear_entries();
        m_e[2] = 1; m_asid[2] = 10'd3; m_vppn[2] = 19'h12200; m_ps[2] = 6'd21;
        run_cmd("srch_2m", 0, 0, 10'd3, 19'h123ff, 0);
        m_ps[2] = 6'd12;
        run_cmd("srch_4k_miss", 0, 0, 10'd3, 19'h123ff, 0);

        // Read of the top index holding an invalid 2M entry.
        m_e[63] = 0; m_ps[63] = 6'd21;
        run_cmd("rd63", 1, 0, 10'd0, 19'd0, 63);
        run_cmd("rsvd", 3, 0, 10'd0, 19'd0, 0);

        // INVTLB op 2 with globals at 0 and 7 (reserved-op timing when not built).
        clear_entries();
        m_e[0] = 1; m_g[0] = 1; m_e[7] = 1; m_g[7] = 1; m_e[8] = 1;
        run_cmd("inv_glb", 2, 2, 10'd0, 19'd0, 0);

        // Reset in the middle of a search aborts it without a result.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.csr_asid = 10'd9; bus.csr_vppn = 19'h7;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", 64'(bus.cmd_ready), 64'd1);
        check("midrst_fields", 64'({bus.TLBSRCH, bus.done, bus.TLBSRCH_hit, bus.TLBSRCH_hit_idx,
                                   bus.TLB_PS, bus.TLB_E}), 64'd0);
        x_hit = 0; x_hit_idx = 0; x_ps = 0; x_e = 0;
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < TLB_NUM + 4; i++) begin
            @(posedge clk); #1;
            if (bus.TLBSRCH || bus.done) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);

        // Random mix of commands against a randomly populated array.
        for (int k = 0; k < 48; k++) begin
            if (k % 8 == 0) rand_entries();
            run_cmd("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    10'($urandom_range(0, 3)),
                    19'h12000 | 19'($urandom_range(0, 3) << 9) | 19'($urandom_range(0, 1)),
                    int'($urandom_range(0, TLB_NUM - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
